// File: rtl/iso_tree_pkg.sv
// Shared types for the isolation-tree walker: node record, FSM states and
// child-index helpers for the implicit heap-ordered binary tree.
package iso_tree_pkg;

  localparam int NODE_DATA_W = 8;
  localparam int NODE_FIDX_W = 2;

  typedef struct packed {
    logic                   leaf;
    logic [NODE_FIDX_W-1:0] feat;
    logic [NODE_DATA_W-1:0] thresh;
  } node_t;

  // Cleared table entries are leaves so an unprogrammed tree stops at the root.
  localparam node_t LEAF_NODE = {1'b1, {NODE_FIDX_W{1'b0}}, {NODE_DATA_W{1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    WALK,
    DONE
  } state_t;

  function automatic int unsigned left_child(input int unsigned n);
    return 2 * n + 1;
  endfunction

  function automatic int unsigned right_child(input int unsigned n);
    return 2 * n + 2;
  endfunction

endpackage

// File: rtl/iso_tree_node_mem.sv
// Node table for the walker: synchronous write while the walker is idle,
// synchronous clear to all-leaf, combinational read of the current node.
module iso_tree_node_mem
  import iso_tree_pkg::*;
#(
  parameter int NODES  = 15,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic              ready,
  input  logic [ADDR_W-1:0] waddr,
  input  node_t             wdata,
  input  logic [ADDR_W-1:0] raddr,
  output node_t             rdata
);

  node_t node_q [NODES];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NODES; i++) begin
        node_q[i] <= LEAF_NODE;
      end
    end else if (we && ready && (int'(waddr) < NODES)) begin
      node_q[waddr] <= wdata;
    end
  end

  // Indices past the table only occur once the walk is at full depth.
  assign rdata = (int'(raddr) < NODES) ? node_q[raddr] : LEAF_NODE;

endmodule

// File: rtl/iso_tree_walker.sv
// Isolation-tree evaluator: walks an accepted sample from the root one level
// per clock and flags paths shorter than the captured anomaly threshold.
module iso_tree_walker
  import iso_tree_pkg::*;
#(
  parameter int DATA_W   = NODE_DATA_W,
  parameter int NUM_FEAT = 3,
  parameter int DEPTH    = 4,
  parameter int FIDX_W   = NODE_FIDX_W,
  localparam int NODES   = (1 << DEPTH) - 1,
  localparam int ADDR_W  = $clog2(NODES),
  localparam int PLEN_W  = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_FEAT*DATA_W-1:0] data_input,
  input  logic                       data_valid,
  output logic                       data_ready,
  input  logic [PLEN_W-1:0]          anom_thresh,
  input  logic                       cfg_we,
  input  logic [ADDR_W-1:0]          cfg_addr,
  input  logic [FIDX_W-1:0]          cfg_feat,
  input  logic [DATA_W-1:0]          cfg_thresh,
  input  logic                       cfg_leaf,
  output logic                       cfg_ready,
  output logic                       result_valid,
  output logic [PLEN_W-1:0]          path_len,
  output logic                       anomaly_detected
);

  state_t                      state;
  logic [NUM_FEAT*DATA_W-1:0]  sample;
  logic [PLEN_W-1:0]           anom_q;
  logic [ADDR_W-1:0]           node;
  logic [PLEN_W-1:0]           depth;
  node_t                       cur;
  node_t                       cfg_node;
  logic [DATA_W-1:0]           feat_val;
  logic                        feat_ok;
  logic                        stop;
  logic [ADDR_W-1:0]           next_node;

  assign cfg_node = '{leaf: cfg_leaf, feat: cfg_feat, thresh: cfg_thresh};

  iso_tree_node_mem #(
    .NODES  (NODES),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (cfg_we),
    .ready (cfg_ready),
    .waddr (cfg_addr),
    .wdata (cfg_node),
    .raddr (node),
    .rdata (cur)
  );

  always_comb begin
    feat_val = '0;
    for (int k = 0; k < NUM_FEAT; k++) begin
      if (FIDX_W'(k) == cur.feat) begin
        feat_val = sample[k*DATA_W +: DATA_W];
      end
    end
  end

  assign feat_ok   = int'(cur.feat) < NUM_FEAT;
  assign stop      = (depth == PLEN_W'(DEPTH)) || cur.leaf || !feat_ok;
  assign next_node = (feat_val < cur.thresh) ? ADDR_W'(left_child(int'(node)))
                                             : ADDR_W'(right_child(int'(node)));

  // The ready flags are registered from the next state so they equal "in IDLE".
  always_ff @(posedge clk) begin
    if (!reset) begin
      state            <= IDLE;
      data_ready       <= 1'b0;
      cfg_ready        <= 1'b0;
      result_valid     <= 1'b0;
      path_len         <= '0;
      anomaly_detected <= 1'b0;
      sample           <= '0;
      anom_q           <= '0;
      node             <= '0;
      depth            <= '0;
    end else begin
      result_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          data_ready <= 1'b1;
          cfg_ready  <= 1'b1;
          if (data_valid && data_ready) begin
            sample     <= data_input;
            anom_q     <= anom_thresh;
            node       <= '0;
            depth      <= '0;
            data_ready <= 1'b0;
            cfg_ready  <= 1'b0;
            state      <= WALK;
          end
        end
        WALK: begin
          if (stop) begin
            path_len         <= depth;
            anomaly_detected <= depth < anom_q;
            result_valid     <= 1'b1;
            state            <= DONE;
          end else begin
            node  <= next_node;
            depth <= depth + 1'b1;
          end
        end
        DONE: begin
          data_ready <= 1'b1;
          cfg_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iso_tree_walker.sv
// Directed bench for iso_tree_walker; cycle 0 is the cycle whose closing edge
// accepts the sample, and all driving/sampling happens at the falling edge.
module tb_iso_tree_walker;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [23:0] data_input = '0;
  logic        data_valid = 1'b0;
  logic        data_ready;
  logic [2:0]  anom_thresh = '0;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_addr = '0;
  logic [1:0]  cfg_feat = '0;
  logic [7:0]  cfg_thresh = '0;
  logic        cfg_leaf = 1'b0;
  logic        cfg_ready;
  logic        result_valid;
  logic [2:0]  path_len;
  logic        anomaly_detected;

  int compared = 0;
  int mismatched = 0;

  iso_tree_walker dut (
    .clk              (clk),
    .reset            (reset),
    .data_input       (data_input),
    .data_valid       (data_valid),
    .data_ready       (data_ready),
    .anom_thresh      (anom_thresh),
    .cfg_we           (cfg_we),
    .cfg_addr         (cfg_addr),
    .cfg_feat         (cfg_feat),
    .cfg_thresh       (cfg_thresh),
    .cfg_leaf         (cfg_leaf),
    .cfg_ready        (cfg_ready),
    .result_valid     (result_valid),
    .path_len         (path_len),
    .anomaly_detected (anomaly_detected)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic writeNode(input int addr, input int feat, input int thresh, input logic leaf);
    @(negedge clk);
    cfg_we     = 1'b1;
    cfg_addr   = 4'(addr);
    cfg_feat   = 2'(feat);
    cfg_thresh = 8'(thresh);
    cfg_leaf   = leaf;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Presents a sample in cycle 0 and returns at the falling edge of cycle 1.
  task automatic applyStimulus(input string tag, input logic [7:0] f0, input logic [7:0] f1,
                               input logic [7:0] f2, input logic [2:0] thr);
    @(negedge clk);
    data_input  = {f2, f1, f0};
    anom_thresh = thr;
    data_valid  = 1'b1;
    checkOutput({tag, ".ready"}, 32'(data_ready), 32'd1);
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  task automatic waitResult(input string tag, input int start_cyc, input int exp_len, input logic exp_anom);
    int cyc;
    cyc = start_cyc;
    while (!result_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput({tag, ".latency"}, 32'(cyc), 32'(exp_len + 2));
    checkOutput({tag, ".path_len"}, 32'(path_len), 32'(exp_len));
    checkOutput({tag, ".anomaly"}, 32'(anomaly_detected), 32'(exp_anom));
    @(negedge clk);
    checkOutput({tag, ".pulse_end"}, 32'(result_valid), 32'd0);
    checkOutput({tag, ".ready_back"}, 32'(data_ready), 32'd1);
  endtask

  initial begin
    int pulses;
    int ready_cyc;

    // Reset held for two edges, then released.
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst.data_ready", 32'(data_ready), 32'd0);
    checkOutput("rst.cfg_ready", 32'(cfg_ready), 32'd0);
    checkOutput("rst.result_valid", 32'(result_valid), 32'd0);
    checkOutput("rst.path_len", 32'(path_len), 32'd0);
    checkOutput("rst.anomaly", 32'(anomaly_detected), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rel.data_ready", 32'(data_ready), 32'd1);
    checkOutput("rel.cfg_ready", 32'(cfg_ready), 32'd1);

    applyStimulus("empty", 8'h00, 8'h00, 8'h00, 3'd1);
    waitResult("empty", 1, 0, 1'b1);

    // Small programmed tree.
    writeNode(0, 0, 8'h80, 1'b0);
    writeNode(1, 0, 8'h00, 1'b1);
    writeNode(2, 1, 8'h40, 1'b0);
    writeNode(5, 0, 8'h00, 1'b1);
    writeNode(6, 0, 8'h00, 1'b1);
    applyStimulus("t2a", 8'h10, 8'h00, 8'h00, 3'd2);
    waitResult("t2a", 1, 1, 1'b1);
    applyStimulus("t2b", 8'hAB, 8'hFF, 8'h00, 3'd2);
    waitResult("t2b", 1, 2, 1'b0);
    applyStimulus("t2c", 8'h80, 8'h3F, 8'h00, 3'd2);
    waitResult("t2c", 1, 2, 1'b0);
    applyStimulus("thr0", 8'h10, 8'h00, 8'h00, 3'd0);
    waitResult("thr0", 1, 1, 1'b0);
    applyStimulus("thr7", 8'hAB, 8'hFF, 8'h00, 3'd7);
    waitResult("thr7", 1, 2, 1'b1);

    // Every node internal on feature 0 with threshold 0: always right, full depth.
    for (int i = 0; i < 15; i++) writeNode(i, 0, 8'h00, 1'b0);
    applyStimulus("full", 8'h55, 8'h00, 8'h00, 3'd4);
    waitResult("full", 1, 4, 1'b0);
    writeNode(0, 3, 8'h00, 1'b0);
    applyStimulus("badfeat", 8'h55, 8'h00, 8'h00, 3'd4);
    waitResult("badfeat", 1, 0, 1'b1);

    // Writes during WALK must be dropped.
    writeNode(0, 0, 8'hFF, 1'b0);
    writeNode(1, 0, 8'h00, 1'b1);
    applyStimulus("busy", 8'h10, 8'h00, 8'h00, 3'd2);
    cfg_we = 1'b1; cfg_addr = 4'd0; cfg_feat = 2'd0; cfg_thresh = 8'h00; cfg_leaf = 1'b0;
    checkOutput("busy.cfg_ready_c1", 32'(cfg_ready), 32'd0);
    checkOutput("busy.data_ready_c1", 32'(data_ready), 32'd0);
    @(negedge clk);
    checkOutput("busy.cfg_ready_c2", 32'(cfg_ready), 32'd0);
    cfg_we = 1'b0;
    waitResult("busy", 2, 1, 1'b1);
    applyStimulus("rerun", 8'h10, 8'h00, 8'h00, 3'd2);
    waitResult("rerun", 1, 1, 1'b1);

    // data_valid held across two samples of path length 1.
    @(negedge clk);
    data_input = {8'h00, 8'h00, 8'h10};
    anom_thresh = 3'd2;
    data_valid = 1'b1;
    checkOutput("hold.ready_c0", 32'(data_ready), 32'd1);
    pulses = 0;
    ready_cyc = -1;
    for (int cyc = 1; cyc <= 15; cyc++) begin
      @(negedge clk);
      if (result_valid) pulses++;
      if (ready_cyc >= 0) data_valid = 1'b0;
      else if (data_ready) ready_cyc = cyc;
    end
    data_valid = 1'b0;
    checkOutput("hold.second_accept", 32'(ready_cyc), 32'd4);
    checkOutput("hold.pulses", 32'(pulses), 32'd2);

    // Reset during a full-depth walk.
    writeNode(2, 0, 8'h00, 1'b0);
    applyStimulus("midrst", 8'hFF, 8'h00, 8'h00, 3'd2);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    checkOutput("midrst.result_valid", 32'(result_valid), 32'd0);
    checkOutput("midrst.path_len", 32'(path_len), 32'd0);
    checkOutput("midrst.anomaly", 32'(anomaly_detected), 32'd0);
    checkOutput("midrst.data_ready", 32'(data_ready), 32'd0);
    checkOutput("midrst.cfg_ready", 32'(cfg_ready), 32'd0);
    pulses = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      if (result_valid) pulses++;
    end
    checkOutput("midrst.no_result", 32'(pulses), 32'd0);
    applyStimulus("cleared", 8'hFF, 8'h00, 8'h00, 3'd1);
    waitResult("cleared", 1, 0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
